// File: rtl/arp_cache.sv
// arp_cache: IP-to-MAC cache fed by ARP receive, aged per tick, sequential-scan lookup; `ARP_CACHE_BCAST_EN answers broadcast lookups directly
module arp_cache #(
  parameter int ENTRIES  = 4,
  parameter int TICK_DIV = 125000000,
  parameter int AGE_MAX  = 300
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        arp_rx_done,
  input  logic        arp_rx_type,
  input  logic [47:0] src_mac,
  input  logic [31:0] src_ip,
  input  logic        lookup_req,
  input  logic [31:0] lookup_ip,
  output logic        lookup_ready,
  output logic        lookup_done,
  output logic        lookup_hit,
  output logic [47:0] lookup_mac,
  output logic [3:0]  entry_count
);
  localparam int IW = ENTRIES > 1 ? $clog2(ENTRIES) : 1;
  localparam int AW = $clog2(AGE_MAX + 1);
  localparam int TW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  localparam logic [IW-1:0] LAST = IW'(ENTRIES - 1);
  typedef enum logic [1:0] {IDLE, INS_SCAN, INS_WR, LKP_SCAN} state_t;
  state_t state;
  logic [ENTRIES-1:0] valid;
  logic [31:0] ip_tab [ENTRIES];
  logic [47:0] mac_tab [ENTRIES];
  logic [AW-1:0] age [ENTRIES];
  logic [TW-1:0] tick_cnt;
  logic [IW-1:0] idx, victim, m_idx, f_idx, tgt;
  logic m_found, f_found, ins_pend, new_ins, tick, eq, unused_type;
  logic [31:0] ins_ip, key_ip;
  logic [47:0] ins_mac, wr_mac;
  assign unused_type = arp_rx_type;
  assign new_ins = arp_rx_done && src_ip != '0;
  assign tick = tick_cnt == TW'(TICK_DIV - 1);
  assign tgt = m_found ? m_idx : f_found ? f_idx : victim;
  assign eq = valid[idx] && ip_tab[idx] == key_ip;
  // A frame arriving this very cycle must be inserted before any lookup is accepted
  assign lookup_ready = state == IDLE && !ins_pend && !new_ins;
  // Table storage and aging; the insert write comes last so it overrides a same-cycle expiry
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt <= '0;
      valid <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        age[i] <= '0;
        ip_tab[i] <= '0;
        mac_tab[i] <= '0;
      end
    end else begin
      tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
      for (int i = 0; i < ENTRIES; i++) begin
        if (tick && valid[i]) begin
          age[i] <= age[i] + 1'b1;
          if (age[i] == AW'(AGE_MAX - 1)) valid[i] <= 1'b0;
        end
        if (state == INS_WR && tgt == IW'(i)) begin
          ip_tab[i] <= key_ip;
          mac_tab[i] <= wr_mac;
          age[i] <= '0;
          valid[i] <= 1'b1;
        end
      end
    end
  end
  // Registered population count of the valid bits
  always_ff @(posedge clk) entry_count <= rst ? '0 : 4'($countones(valid));
  // Control FSM; the pending pair is snapshotted at scan start so later arrivals cannot corrupt an in-flight scan
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx <= '0;
      victim <= '0;
      m_idx <= '0;
      f_idx <= '0;
      m_found <= 1'b0;
      f_found <= 1'b0;
      ins_pend <= 1'b0;
      ins_ip <= '0;
      ins_mac <= '0;
      key_ip <= '0;
      wr_mac <= '0;
      lookup_done <= 1'b0;
      lookup_hit <= 1'b0;
      lookup_mac <= '0;
    end else begin
      lookup_done <= 1'b0;
      lookup_hit <= 1'b0;
      lookup_mac <= '0;
      if (new_ins) begin
        ins_pend <= 1'b1;
        ins_ip <= src_ip;
        ins_mac <= src_mac;
      end
      case (state)
        IDLE: begin
          if (ins_pend) begin
            state <= INS_SCAN;
            idx <= '0;
            m_found <= 1'b0;
            f_found <= 1'b0;
            key_ip <= ins_ip;
            wr_mac <= ins_mac;
            if (!new_ins) ins_pend <= 1'b0;
          end else if (lookup_req && lookup_ready) begin
`ifdef ARP_CACHE_BCAST_EN
            if (&lookup_ip) begin
              lookup_done <= 1'b1;
              lookup_hit <= 1'b1;
              lookup_mac <= '1;
            end else begin
              state <= LKP_SCAN;
              idx <= '0;
              key_ip <= lookup_ip;
            end
`else
            state <= LKP_SCAN;
            idx <= '0;
            key_ip <= lookup_ip;
`endif
          end
        end
        INS_SCAN: begin
          if (eq && !m_found) begin
            m_found <= 1'b1;
            m_idx <= idx;
          end
          if (!valid[idx] && !f_found) begin
            f_found <= 1'b1;
            f_idx <= idx;
          end
          idx <= idx + 1'b1;
          if (idx == LAST) state <= INS_WR;
        end
        INS_WR: begin
          if (!m_found && !f_found) victim <= victim == LAST ? '0 : victim + 1'b1;
          state <= IDLE;
        end
        default: begin
          if (eq || idx == LAST) begin
            lookup_done <= 1'b1;
            lookup_hit <= eq;
            lookup_mac <= eq ? mac_tab[idx] : '0;
            state <= IDLE;
          end
          idx <= idx + 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_arp_cache.sv
// tb_arp_cache: directed and randomized checks of arp_cache against a slot-level reference model, plus a fast-aging instance
`timescale 1ns/1ps
module tb_arp_cache;
  localparam int N = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic arp_rx_done = 1'b0, arp_rx_type = 1'b0, lookup_req = 1'b0;
  logic [47:0] src_mac = '0;
  logic [31:0] src_ip = '0, lookup_ip = '0;
  logic lookup_ready, lookup_done, lookup_hit;
  logic [47:0] lookup_mac;
  logic [3:0] entry_count;
  logic a_arp_rx_done = 1'b0, a_lookup_req = 1'b0;
  logic [47:0] a_src_mac = '0;
  logic [31:0] a_src_ip = '0, a_lookup_ip = '0;
  logic a_lookup_ready, a_lookup_done, a_lookup_hit;
  logic [47:0] a_lookup_mac;
  logic [3:0] a_entry_count;
  arp_cache #(.ENTRIES(N), .TICK_DIV(1000000), .AGE_MAX(300)) dut (
    .clk(clk), .rst(rst), .arp_rx_done(arp_rx_done), .arp_rx_type(arp_rx_type),
    .src_mac(src_mac), .src_ip(src_ip), .lookup_req(lookup_req), .lookup_ip(lookup_ip),
    .lookup_ready(lookup_ready), .lookup_done(lookup_done), .lookup_hit(lookup_hit),
    .lookup_mac(lookup_mac), .entry_count(entry_count));
  arp_cache #(.ENTRIES(N), .TICK_DIV(4), .AGE_MAX(3)) age_dut (
    .clk(clk), .rst(rst), .arp_rx_done(a_arp_rx_done), .arp_rx_type(1'b1),
    .src_mac(a_src_mac), .src_ip(a_src_ip), .lookup_req(a_lookup_req), .lookup_ip(a_lookup_ip),
    .lookup_ready(a_lookup_ready), .lookup_done(a_lookup_done), .lookup_hit(a_lookup_hit),
    .lookup_mac(a_lookup_mac), .entry_count(a_entry_count));
  int n_cmp = 0, n_bad = 0, ins_wait, a_wait;
  logic [31:0] m_ip [N];
  logic [47:0] m_mac [N];
  bit m_v [N];
  int m_victim;
  logic [31:0] rip;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic int m_find(input logic [31:0] ip);
    for (int i = 0; i < N; i++) if (m_v[i] && m_ip[i] == ip) return i;
    return -1;
  endfunction
  function automatic int m_count();
    int c = 0;
    foreach (m_v[i]) c += int'(m_v[i]);
    return c;
  endfunction
  task automatic m_reset();
    foreach (m_v[i]) m_v[i] = 1'b0;
    m_victim = 0;
  endtask
  task automatic m_insert(input logic [31:0] ip, input logic [47:0] mac);
    int s = m_find(ip);
    if (s < 0) for (int i = N - 1; i >= 0; i--) if (!m_v[i]) s = i;
    if (s < 0) begin
      s = m_victim;
      m_victim = (m_victim + 1) % N;
    end
    m_ip[s] = ip;
    m_mac[s] = mac;
    m_v[s] = 1'b1;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    m_reset();
  endtask
  task automatic do_insert(input logic [31:0] ip, input logic [47:0] mac);
    src_ip = ip;
    src_mac = mac;
    arp_rx_type = 1'($urandom);
    arp_rx_done = 1'b1;
    @(posedge clk);
    #1 arp_rx_done = 1'b0;
    ins_wait = 0;
    while (!lookup_ready && ins_wait < 100) begin
      @(posedge clk);
      #1 ins_wait++;
    end
    @(posedge clk);
    #1;
    if (ip != 32'h0) m_insert(ip, mac);
  endtask
  task automatic do_lookup(input logic [31:0] ip, output int w, output int lat, output logic h, output logic [47:0] m);
    lookup_ip = ip;
    lookup_req = 1'b1;
    w = 0;
    while (!lookup_ready && w < 100) begin
      @(posedge clk);
      #1 w++;
    end
    @(posedge clk);
    #1 lookup_req = 1'b0;
    lat = 1;
    while (!lookup_done && lat < 100) begin
      @(posedge clk);
      #1 lat++;
    end
    h = lookup_hit;
    m = lookup_mac;
  endtask
  task automatic check_lookup(input string tag, input logic [31:0] ip);
    int s = m_find(ip), w, lat;
    logic h;
    logic [47:0] m;
    do_lookup(ip, w, lat, h, m);
    chk({tag, "_lat"}, 64'(lat), 64'(s < 0 ? N + 1 : s + 2));
    chk({tag, "_hit"}, 64'(h), 64'(s >= 0));
    chk({tag, "_mac"}, 64'(m), 64'(s < 0 ? 48'h0 : m_mac[s]));
  endtask
  task automatic a_insert(input logic [31:0] ip);
    a_src_ip = ip;
    a_src_mac = {16'h0, ip};
    a_arp_rx_done = 1'b1;
    @(posedge clk);
    #1 a_arp_rx_done = 1'b0;
    a_wait = 0;
    while (!a_lookup_ready && a_wait < 100) begin
      @(posedge clk);
      #1 a_wait++;
    end
  endtask
  task automatic a_lookup(input logic [31:0] ip, output logic h);
    int n = 0;
    a_lookup_ip = ip;
    a_lookup_req = 1'b1;
    @(posedge clk);
    #1 a_lookup_req = 1'b0;
    while (!a_lookup_done && n < 100) begin
      @(posedge clk);
      #1 n++;
    end
    h = a_lookup_hit;
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected summary");
    $fatal(1);
  end
  initial begin
    int w, lat;
    logic h, seen;
    logic [47:0] m;
    m_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_ready", 64'(lookup_ready), 64'(1));
    chk("rst_done", 64'(lookup_done), 64'(0));
    chk("rst_hit", 64'(lookup_hit), 64'(0));
    chk("rst_mac", 64'(lookup_mac), 64'(0));
    chk("rst_cnt", 64'(entry_count), 64'(0));
    check_lookup("empty", 32'hC0A80166);
    chk("empty_cnt", 64'(entry_count), 64'(0));
    do_insert(32'hC0A80166, 48'h000EC6112233);
    chk("ins_wait", 64'(ins_wait), 64'(N + 2));
    chk("ins_cnt", 64'(entry_count), 64'(1));
    check_lookup("ins", 32'hC0A80166);
    @(posedge clk);
    #1 chk("strobe_done", 64'(lookup_done), 64'(0));
    chk("strobe_mac", 64'(lookup_mac), 64'(0));
    do_insert(32'hC0A80166, 48'hAABBCCDDEEFF);
    chk("upd_cnt", 64'(entry_count), 64'(1));
    check_lookup("upd", 32'hC0A80166);
    do_reset();
    for (int i = 1; i <= 5; i++) do_insert(32'hC0A80100 + 32'(i), 48'h020000000000 + 48'(i));
    chk("repl_cnt", 64'(entry_count), 64'(4));
    check_lookup("repl_old", 32'hC0A80101);
    check_lookup("repl_new", 32'hC0A80105);
    do_insert(32'h0, 48'h1);
    chk("probe_wait", 64'(ins_wait), 64'(0));
    chk("probe_cnt", 64'(entry_count), 64'(4));
    src_ip = 32'hC0A80177;
    src_mac = 48'h0A0B0C0D0E0F;
    arp_rx_done = 1'b1;
    lookup_ip = 32'hC0A80177;
    lookup_req = 1'b1;
    #1 chk("same_ready", 64'(lookup_ready), 64'(0));
    @(posedge clk);
    #1 arp_rx_done = 1'b0;
    m_insert(32'hC0A80177, 48'h0A0B0C0D0E0F);
    do_lookup(32'hC0A80177, w, lat, h, m);
    chk("same_wait", 64'(w), 64'(N + 2));
    chk("same_lat", 64'(lat), 64'(m_find(32'hC0A80177) + 2));
    chk("same_hit", 64'(h), 64'(1));
    chk("same_mac", 64'(m), 64'(48'h0A0B0C0D0E0F));
`ifdef ARP_CACHE_BCAST_EN
    do_lookup(32'hFFFFFFFF, w, lat, h, m);
    chk("bcast_lat", 64'(lat), 64'(1));
    chk("bcast_hit", 64'(h), 64'(1));
    chk("bcast_mac", 64'(m), 64'(48'hFFFFFFFFFFFF));
    chk("bcast_ready", 64'(lookup_ready), 64'(1));
`else
    check_lookup("bcast", 32'hFFFFFFFF);
`endif
    do_reset();
    for (int it = 0; it < 80; it++) begin
      rip = 32'h0A000000 | 32'($urandom_range(1, 8));
      if ($urandom_range(0, 2) == 0) begin
        do_insert($urandom_range(0, 5) == 0 ? 32'h0 : rip, 48'({$urandom, $urandom}));
        chk("rnd_cnt", 64'(entry_count), 64'(m_count()));
      end else check_lookup("rnd", rip);
    end
    lookup_ip = 32'h0A000001;
    lookup_req = 1'b1;
    @(posedge clk);
    #1 lookup_req = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    m_reset();
    seen = 1'b0;
    repeat (N + 3) begin
      @(posedge clk);
      #1 seen |= lookup_done;
    end
    chk("abort_done", 64'(seen), 64'(0));
    chk("abort_ready", 64'(lookup_ready), 64'(1));
    chk("abort_cnt", 64'(entry_count), 64'(0));
    do_reset();
    a_insert(32'h0A0000AA);
    chk("age_ins_wait", 64'(a_wait), 64'(N + 2));
    @(posedge clk);
    #1 chk("age_cnt1", 64'(a_entry_count), 64'(1));
    repeat (13) @(posedge clk);
    #1 chk("age_cnt0", 64'(a_entry_count), 64'(0));
    a_lookup(32'h0A0000AA, h);
    chk("age_miss", 64'(h), 64'(0));
    a_insert(32'h0A0000BB);
    a_insert(32'h0A0000BB);
    chk("age_ref_wait", 64'(a_wait), 64'(N + 2));
    repeat (7) @(posedge clk);
    #1 chk("age_ref_cnt", 64'(a_entry_count), 64'(1));
    a_lookup(32'h0A0000BB, h);
    chk("age_ref_hit", 64'(h), 64'(1));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
